// File: rtl/cnt_sweep_pkg.sv
// Shared types and defaults for the counter sweep controller.
package cnt_sweep_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned PASS_W_DEF = 8;

  typedef enum logic [1:0] {
    ONESHOT = 2'd0,
    REPEAT  = 2'd1,
    BOUNCE  = 2'd2
  } sweep_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  // The unused encoding 3 behaves as a one-shot sweep.
  function automatic sweep_mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return REPEAT;
      2'd2:    return BOUNCE;
      default: return ONESHOT;
    endcase
  endfunction

endpackage

// File: rtl/cnt_sweep_ctrl.sv
// Sequencer that drives a loadable up/down counter between two programmed
// endpoints in one-shot, repeat or bounce mode for a number of passes.
module cnt_sweep_ctrl
  import cnt_sweep_pkg::*;
#(
  parameter int W  = CNT_W_DEF,
  parameter int PW = PASS_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    cfg_mode,
  input  logic [W-1:0]  cfg_start,
  input  logic [W-1:0]  cfg_end,
  input  logic [PW-1:0] cfg_passes,
  input  logic [W-1:0]  cnt_value,
  output logic [W-1:0]  cnt_data,
  output logic          cnt_ld_n,
  output logic          cnt_updn,
  output logic          cnt_enb,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] pass_cnt
);

  ctrl_state_t   state_q;
  sweep_mode_t   mode_q;
  logic [W-1:0]  start_val_q;
  logic [W-1:0]  end_val_q;
  logic [PW-1:0] passes_q;
  logic [W-1:0]  target_q;
  logic          dir_up_q;
  logic [PW-1:0] pass_cnt_q;
  logic [W-1:0]  cnt_data_q;
  logic          cnt_ld_n_q;
  logic          busy_q;
  logic          done_q;

  logic          at_target;
  logic [PW-1:0] pass_inc;
  logic [PW-1:0] pass_cnt_d;
  logic          last_pass;

  assign at_target  = (cnt_value == target_q);
  assign pass_inc   = pass_cnt_q + PW'(1);
  assign pass_cnt_d = (&pass_cnt_q) ? pass_cnt_q : pass_inc;
  // A one-shot sweep ends after its first pass; otherwise a zero pass count
  // means the sweep only ends on stop.
  assign last_pass  = (mode_q == ONESHOT) ||
                      ((passes_q != '0) && (pass_inc == passes_q));

  // Count enable follows the live counter value so the counter stops exactly
  // on the target, and is killed in the same cycle that stop arrives.
  assign cnt_enb  = (state_q == RUN) && !stop && !at_target;

  assign cnt_data = cnt_data_q;
  assign cnt_ld_n = cnt_ld_n_q;
  assign cnt_updn = dir_up_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_cnt_q;

  // Sweep state machine with registered counter controls and status.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every register here, including latched config, gets a defined
    // reset value so the counter sees idle controls straight out of reset.
    if (!rst) begin
      state_q     <= IDLE;
      mode_q      <= ONESHOT;
      start_val_q <= '0;
      end_val_q   <= '0;
      passes_q    <= '0;
      target_q    <= '0;
      dir_up_q    <= 1'b1;
      pass_cnt_q  <= '0;
      cnt_data_q  <= '0;
      cnt_ld_n_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (stop) begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // reads the pre-edge values of the other registers.
      state_q    <= IDLE;
      cnt_ld_n_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q      <= decode_mode(cfg_mode);
            start_val_q <= cfg_start;
            end_val_q   <= cfg_end;
            passes_q    <= cfg_passes;
            target_q    <= cfg_end;
            dir_up_q    <= (cfg_end >= cfg_start);
            pass_cnt_q  <= '0;
            cnt_data_q  <= cfg_start;
            cnt_ld_n_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end

        LOAD: begin
          cnt_ld_n_q <= 1'b1;
          state_q    <= RUN;
        end

        RUN: begin
          if (at_target) begin
            pass_cnt_q <= pass_cnt_d;
            if (last_pass) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (mode_q == BOUNCE) begin
              // Reverse in place; the counter holds for this one cycle.
              dir_up_q <= !dir_up_q;
              target_q <= (target_q == end_val_q) ? start_val_q : end_val_q;
            end else begin
              cnt_data_q <= start_val_q;
              cnt_ld_n_q <= 1'b0;
              state_q    <= LOAD;
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Self-checking bench for cnt_sweep_ctrl: a behavioural counter closes the
// loop, and the expected per-cycle trace is built leg by leg from endpoints.
module tb_cnt_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_start = '0;
  logic [15:0] cfg_end = '0;
  logic [7:0]  cfg_passes = '0;
  logic [15:0] cnt_q;
  logic [15:0] cnt_data;
  logic        cnt_ld_n, cnt_updn, cnt_enb, busy, done;
  logic [7:0]  pass_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        ld_n;
    logic        busy;
    logic        done;
    logic        enb;
    logic        chk_updn;
    logic        updn;
    logic        chk_val;
    logic [15:0] val;
    logic [7:0]  pc;
    logic [15:0] data;
  } rec_t;

  rec_t exp_q[$];

  cnt_sweep_ctrl #(.W(16), .PW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_mode   (cfg_mode),
    .cfg_start  (cfg_start),
    .cfg_end    (cfg_end),
    .cfg_passes (cfg_passes),
    .cnt_value  (cnt_q),
    .cnt_data   (cnt_data),
    .cnt_ld_n   (cnt_ld_n),
    .cnt_updn   (cnt_updn),
    .cnt_enb    (cnt_enb),
    .busy       (busy),
    .done       (done),
    .pass_cnt   (pass_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model of the team's loadable up/down counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           cnt_q <= '0;
    else if (!cnt_ld_n) cnt_q <= cnt_data;
    else if (cnt_enb)   cnt_q <= cnt_updn ? cnt_q + 16'd1 : cnt_q - 16'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected trace: each pass is one leg from a to b inclusive; repeat mode
  // reloads before every leg, bounce alternates leg direction.
  task automatic build(input int mode, input int s, input int e, input int legs);
    rec_t r;
    int a, b, n, v;
    exp_q.delete();
    for (int l = 0; l < legs; l++) begin
      a = (mode == 2 && (l % 2) == 1) ? e : s;
      b = (mode == 2 && (l % 2) == 1) ? s : e;
      if (l == 0 || mode == 1) begin
        r = '{ld_n: 1'b0, busy: 1'b1, done: 1'b0, enb: 1'b0, chk_updn: 1'b0,
              updn: 1'b0, chk_val: 1'b0, val: '0, pc: 8'(l), data: 16'(s)};
        exp_q.push_back(r);
      end
      n = (b >= a) ? b - a : a - b;
      for (int k = 0; k <= n; k++) begin
        v = (b >= a) ? a + k : a - k;
        r = '{ld_n: 1'b1, busy: 1'b1, done: 1'b0, enb: (k != n), chk_updn: (k != n),
              updn: (b >= a), chk_val: 1'b1, val: 16'(v), pc: 8'(l), data: '0};
        exp_q.push_back(r);
      end
    end
    r = '{ld_n: 1'b1, busy: 1'b0, done: 1'b1, enb: 1'b0, chk_updn: 1'b0, updn: 1'b0,
          chk_val: 1'b1, val: 16'(b), pc: 8'((legs > 255) ? 255 : legs), data: '0};
    exp_q.push_back(r);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " ld_n"}, cnt_ld_n, 1'b1);
    check({name, " enb"},  cnt_enb,  1'b0);
    check({name, " updn"}, cnt_updn, 1'b1);
    check({name, " data"}, cnt_data, 16'd0);
    check({name, " busy"}, busy,     1'b0);
    check({name, " done"}, done,     1'b0);
    check({name, " pcnt"}, pass_cnt, 8'd0);
  endtask

  // Runs one sweep; stop_idx/glitch_idx/rst_idx inject events at a trace index (-1 = none).
  task automatic run_sweep(input string name, input int mode, input int s, input int e,
                           input int passes, input int legs_if_endless,
                           input int stop_idx, input int glitch_idx, input int rst_idx);
    int legs;
    rec_t r;
    string t;
    if (mode == 1 || mode == 2) legs = (passes == 0) ? legs_if_endless : passes;
    else                        legs = 1;
    build(mode, s, e, legs);
    @(negedge clk);
    cfg_mode = 2'(mode); cfg_start = 16'(s); cfg_end = 16'(e); cfg_passes = 8'(passes);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      r = exp_q[i];
      if (i == rst_idx) begin
        rst = 1'b0;
        #1;
        check_reset_outputs({name, " midrst"});
        return;
      end
      if (i == stop_idx) stop = 1'b1;
      if (i == glitch_idx) begin
        start = 1'b1; cfg_start = cfg_start + 16'd77; cfg_mode = 2'd2;
      end
      @(negedge clk);
      t = $sformatf("%s[%0d]", name, i);
      check({t, " ld_n"}, cnt_ld_n, r.ld_n);
      check({t, " busy"}, busy,     r.busy);
      check({t, " done"}, done,     r.done);
      check({t, " enb"},  cnt_enb,  stop ? 1'b0 : r.enb);
      check({t, " pcnt"}, pass_cnt, r.pc);
      if (r.chk_val)  check({t, " val"},  cnt_q,    r.val);
      if (r.chk_updn) check({t, " updn"}, cnt_updn, r.updn);
      if (!r.ld_n)    check({t, " data"}, cnt_data, r.data);
      @(posedge clk); #1;
      start = 1'b0;
      if (stop) begin
        stop = 1'b0;
        return;
      end
    end
    // One cycle after the done pulse: back to idle, counter holding.
    @(negedge clk);
    check({name, " post busy"}, busy,    1'b0);
    check({name, " post done"}, done,    1'b0);
    check({name, " post enb"},  cnt_enb, 1'b0);
    check({name, " post val"},  cnt_q,   r.val);
  endtask

  initial begin
    int s, e, m, p;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    run_sweep("oneshot_up",   0, 3,  6,  0, 0, -1, -1, -1);
    run_sweep("oneshot_down", 0, 10, 7,  0, 0, -1, -1, -1);
    run_sweep("repeat_0_2",   1, 0,  2,  3, 0, -1, -1, -1);
    run_sweep("bounce_5_7",   2, 5,  7,  4, 0, -1, -1, -1);
    run_sweep("bounce_eq",    2, 9,  9,  255, 0, -1, -1, -1);
    run_sweep("repeat_eq",    1, 40, 40, 2, 0, -1, -1, -1);
    run_sweep("mode3",        3, 20, 23, 5, 0, -1, -1, -1);

    // Bounce 0->3 endless, stop when the down leg reaches 2 (trace index 6).
    run_sweep("bounce_stop",  2, 0,  3,  0, 4, 6, -1, -1);
    repeat (3) begin
      @(negedge clk);
      check("stop hold val",  cnt_q,    16'd2);
      check("stop hold busy", busy,     1'b0);
      check("stop hold done", done,     1'b0);
      check("stop hold pcnt", pass_cnt, 8'd1);
    end

    // Start pulse mid-RUN is ignored; reset mid-RUN clears everything.
    run_sweep("repeat_rst", 1, 100, 200, 2, 0, -1, 20, 60);
    @(negedge clk);
    check_reset_outputs("held reset");
    rst = 1'b1;
    run_sweep("after_rst", 0, 500, 505, 0, 0, -1, -1, -1);

    // Start and stop together in idle: stop wins.
    @(negedge clk);
    start = 1'b1; stop = 1'b1; cfg_mode = 2'd0; cfg_start = 16'd1; cfg_end = 16'd9;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("start_stop busy", busy,     1'b0);
    check("start_stop ld_n", cnt_ld_n, 1'b1);

    for (int it = 0; it < 10; it++) begin
      m = int'($urandom_range(0, 3));
      s = int'($urandom_range(100, 60000));
      e = s + int'($urandom_range(0, 24)) - 12;
      p = (m == 1 || m == 2) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 4));
      run_sweep($sformatf("rand%0d", it), m, s, e, p, 0, -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnt_sweep_ctrl.md
Name: cnt_sweep_ctrl

Overview:
- Sequencer for the team's 16-bit loadable up/down counter (active-low load, up/down select, count enable).
- Drives the counter's control/data inputs and reads back its count.
- Sweeps the count between two programmed endpoints in one-shot, repeat or bounce mode for a programmed number of passes.
- Sits between a register/CPU-side config interface and the counter instance; reports busy/done.

Parameters:
- W, 16, counter/endpoint width; must match the counter.
- PW, 8, width of the pass-count config and internal pass counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a sweep; ignored while busy
- stop  input  1  abort; highest priority after reset
- cfg_mode  input  2  sweep_mode_t: ONESHOT=0, REPEAT=1, BOUNCE=2; 3 treated as ONESHOT
- cfg_start  input  W  first endpoint
- cfg_end  input  W  second endpoint
- cfg_passes  input  PW  passes to run; 0 = run until stop
- cnt_value  input  W  counter's data_out
- cnt_data  output  W  to counter data_in
- cnt_ld_n  output  1  to counter ld_cnt (active low)
- cnt_updn  output  1  to counter updn_cnt (1 = up)
- cnt_enb  output  1  to counter count_enb
- busy  output  1  high in LOAD/RUN
- done  output  1  one-cycle pulse at normal completion
- pass_cnt  output  PW  passes completed in the current sweep

Behaviour:
- Reset (rst low, async):
  - state=IDLE, cnt_ld_n=1, cnt_enb=0, cnt_updn=1, cnt_data=0, busy=0, done=0, pass_cnt=0.
  - Latched config is cleared to 0.
- States: IDLE, LOAD, RUN, DONE. State, latched config, direction, target and pass_cnt are all registered.
- IDLE:
  - On start=1 and stop=0: latch cfg_*, set pass_cnt=0, go to LOAD.
  - Direction latch dir_up = (cfg_end >= cfg_start), unsigned compare.
  - target=cfg_end.
- LOAD (exactly 1 cycle):
  - cnt_ld_n=0, cnt_data=start_q, cnt_enb=0. The counter holds start_q from the next edge.
  - Next state RUN.
- RUN:
  - cnt_updn=dir_up.
  - cnt_enb=1 iff cnt_value != target (combinational from cnt_value).
  - Pass-end condition: cnt_value == target.
    - pass_cnt increments, saturating at all-ones.
    - Last pass means passes_q != 0 and pass_cnt+1 == passes_q; ONESHOT always counts as last.
    - Last pass: go to DONE.
    - REPEAT, not last: go to LOAD (reload start_q, same direction).
    - BOUNCE, not last: stay in RUN, invert dir_up, swap target between start_q and end_q. The counter holds for that one cycle.
- DONE (1 cycle): done=1, busy=0, all counter controls idle. Next state IDLE.
- Counter control outside LOAD/RUN: cnt_ld_n=1 and cnt_enb=0. The counter holds its value.
- stop=1 in any state: next state IDLE, cnt_enb=0 combinationally in that cycle, no done pulse. pass_cnt keeps its value.
- start while busy or in DONE: ignored. Simultaneous start and stop in IDLE: stop wins.
- Endpoints equal: each pass takes 1 RUN cycle after LOAD. In BOUNCE, each cycle is a pass.
- No wrap-around: the controller never counts past a target, so the counter never wraps.
- Timing, ONESHOT start=3, end=6, with start sampled at edge k:
  - LOAD during cycle k+1.
  - RUN during k+2..k+5, cnt_value 3,4,5,6.
  - done during k+6.

Decomposition:
- Package cnt_sweep_pkg holds:
  - typedef enum sweep_mode_t {ONESHOT, REPEAT, BOUNCE}
  - typedef enum ctrl_state_t {IDLE, LOAD, RUN, DONE}
  - localparams for the default W and PW
- The controller is a single module with no sub-modules.
- Integration/test top cnt_sweep_top instantiates cnt_sweep_ctrl with the existing 16-bit counter, with its data_out fed back to cnt_value.

Test Plan:
- ONESHOT 3->6, passes=0 -> cnt_value sequence 3,4,5,6. done pulses exactly 1 cycle, 5 cycles after LOAD. Counter holds 6. pass_cnt=1.
- ONESHOT 10->7 -> cnt_updn=0, sequence 10,9,8,7, done pulse, final 7.
- REPEAT 0->2, passes=3 -> the sequence 0,1,2 runs three times with a LOAD cycle before each. done after the third pass. pass_cnt=3.
- BOUNCE 5->7, passes=4 -> sequence 5,6,7,7,6,5,5,6,7,7,6,5 (hold cycle at each reversal). done follows. pass_cnt=4.
- BOUNCE 0->3, passes=0, stop asserted when cnt_value=2 on the down leg -> cnt_enb drops the same cycle, counter holds 2, busy=0, no done pulse.
- Reset asserted mid-RUN (REPEAT 100->200) -> all outputs return to reset values immediately. A start pulse during RUN changes nothing, and a start after reset release begins a fresh sweep from the new cfg_start.
